// File: rtl/ps2_key_event_pkg.sv
// Shared types and constants for the PS/2 key event decoder.
package ps2_key_event_pkg;

  // Scancode prefix decoder states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_st_e;

  localparam logic [7:0] SC_EXT = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK = 8'hF0;  // release prefix

  // Event as stored in the FIFO
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  // Keyboard replies / error codes that never start or finish a key event
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hE1, 8'hEE,
      8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Key event stream: FWFT head of the event FIFO with a valid/ready pop.
interface ps2_key_event_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_key_event_evt_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO only lands when
// the same cycle also pops.
module evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  // Read/write pointers, extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // Storage, no reset needed since empty masks stale entries
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scancode-to-key-event decoder: pops bytes from a receiver, strips
// E0/F0 prefixes, tracks the held key and counts presses.
module ps2_key_event
  import ps2_key_event_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 8,
  parameter int IGNORE_REPEAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             kb_clrn,
  ps2_key_event_if.master  evt,
  output logic [CNT_W-1:0] press_count,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic             evt_drop,
  output logic             ovf_sticky
);
  dec_st_e          state_q, state_d;
  logic             nextdata_n_q;
  logic             clrn_q, ovf_q, drop_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             key_held_q, key_held_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;

  logic             acc, ev_vld, hit, rep, push, pop;
  logic             fifo_empty, fifo_full;
  evt_t             ev, head;

  // A byte is taken only when the pop strobe is idle and no overflow is flagged
  assign acc = kb_ready && !kb_overflow && nextdata_n_q;

  // Prefix decoder: next state and the decoded event for this byte
  always_comb begin
    state_d = state_q;
    ev_vld  = 1'b0;
    ev      = '0;
    if (kb_overflow) begin
      state_d = ST_IDLE;
    end else if (acc) begin
      case (state_q)
        ST_IDLE: begin
          if (kb_data == SC_EXT)      state_d = ST_E0;
          else if (kb_data == SC_BRK) state_d = ST_F0;
          else if (!is_ignored(kb_data)) begin
            ev_vld = 1'b1;
            ev     = '{code: kb_data, ext: 1'b0, brk: 1'b0};
          end
        end
        ST_E0: begin
          if (kb_data == SC_BRK)      state_d = ST_E0F0;
          else if (kb_data != SC_EXT) begin
            ev_vld  = 1'b1;
            ev      = '{code: kb_data, ext: 1'b1, brk: 1'b0};
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          ev_vld  = 1'b1;
          ev      = '{code: kb_data, ext: 1'b0, brk: 1'b1};
          state_d = ST_IDLE;
        end
        default: begin
          ev_vld  = 1'b1;
          ev      = '{code: kb_data, ext: 1'b1, brk: 1'b1};
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Held-key tracking, repeat suppression and press counting
  always_comb begin
    count_d     = count_q;
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    hit  = key_held_q && (held_code_q == ev.code) && (held_ext_q == ev.ext);
    rep  = ev_vld && !ev.brk && hit && (IGNORE_REPEAT != 0);
    push = ev_vld && !rep;
    if (push && !ev.brk) begin
      count_d     = count_q + 1'b1;
      key_held_d  = 1'b1;
      held_code_d = ev.code;
      held_ext_d  = ev.ext;
    end
    if (push && ev.brk && hit) key_held_d = 1'b0;
  end

  assign pop = !fifo_empty && evt.evt_ready;

  // Decoder state, receiver handshakes, status flags and key tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      clrn_q       <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      count_q      <= '0;
      key_held_q   <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= !acc;
      clrn_q       <= !kb_overflow;
      if (kb_overflow) ovf_q <= 1'b1;
      drop_q       <= push && fifo_full && !pop;
      count_q      <= count_d;
      key_held_q   <= key_held_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
    end
  end

  evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (ev),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = head.code;
  assign evt.evt_ext   = head.ext;
  assign evt.evt_break = head.brk;

  assign kb_nextdata_n = nextdata_n_q;
  assign kb_clrn       = clrn_q;
  assign press_count   = count_q;
  assign key_held      = key_held_q;
  assign held_code     = held_code_q;
  assign held_ext      = held_ext_q;
  assign evt_drop      = drop_q;
  assign ovf_sticky    = ovf_q;
endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench: three decoders share the byte stream -- default build,
// repeats passed through, and a 4-bit press counter.
module tb_ps2_key_event;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0, kb_overflow = 1'b0;
  logic       rdy0 = 1'b0, rdy1 = 1'b1, rdy2 = 1'b1;

  logic [2:0] nd_n, clrn, kh, hx, drp, ovf;
  logic [7:0] hc [3];
  logic [7:0] pc0, pc1;
  logic [3:0] pc2;

  int n_vec = 0, n_err = 0;
  int n_ev1 = 0, n_drop0 = 0;

  always #5 clk = ~clk;

  ps2_key_event_if if0 ();
  ps2_key_event_if if1 ();
  ps2_key_event_if if2 ();
  assign if0.evt_ready = rdy0;
  assign if1.evt_ready = rdy1;
  assign if2.evt_ready = rdy2;

  ps2_key_event dut0 (
    .clk(clk), .reset(reset), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(nd_n[0]), .kb_clrn(clrn[0]),
    .evt(if0), .press_count(pc0), .key_held(kh[0]), .held_code(hc[0]),
    .held_ext(hx[0]), .evt_drop(drp[0]), .ovf_sticky(ovf[0]));

  ps2_key_event #(.IGNORE_REPEAT(0)) dut1 (
    .clk(clk), .reset(reset), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(nd_n[1]), .kb_clrn(clrn[1]),
    .evt(if1), .press_count(pc1), .key_held(kh[1]), .held_code(hc[1]),
    .held_ext(hx[1]), .evt_drop(drp[1]), .ovf_sticky(ovf[1]));

  ps2_key_event #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(nd_n[2]), .kb_clrn(clrn[2]),
    .evt(if2), .press_count(pc2), .key_held(kh[2]), .held_code(hc[2]),
    .held_ext(hx[2]), .evt_drop(drp[2]), .ovf_sticky(ovf[2]));

  // Count events leaving dut1 and drop pulses from dut0
  always @(posedge clk) begin
    if (reset) begin
      n_ev1   <= 0;
      n_drop0 <= 0;
    end else begin
      if (if1.evt_valid && if1.evt_ready) n_ev1 <= n_ev1 + 1;
      if (drp[0]) n_drop0 <= n_drop0 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if0.evt_valid, 0);
    chk("rst_count", pc0, 0);
    chk("rst_held",  {kh[0], hc[0], hx[0]}, 0);
    chk("rst_drop",  drp[0], 0);
    chk("rst_ovf",   ovf[0], 0);
    chk("rst_ndn",   nd_n[0], 1);
    chk("rst_clrn",  clrn[0], 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_clrn_rel", clrn[0], 1);
  endtask

  // One byte offered for a single cycle, then an idle cycle
  task automatic send(input logic [7:0] b);
    kb_data  = b;
    kb_ready = 1'b1;
    @(posedge clk); #1;
    kb_ready = 1'b0;
    chk("ndn_lo", nd_n[0], 0);
    @(posedge clk); #1;
    chk("ndn_hi", nd_n[0], 1);
  endtask

  task automatic pop0(input string tag, input logic [7:0] c, input logic e, input logic k);
    chk({tag, "_v"}, if0.evt_valid, 1);
    chk(tag, {if0.evt_code, if0.evt_ext, if0.evt_break}, {c, e, k});
    rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
  endtask

  initial begin
    // make/break of a plain key
    do_reset();
    send(8'h1C);
    chk("t1_held", {kh[0], hc[0], hx[0]}, {1'b1, 8'h1C, 1'b0});
    send(8'hF0); send(8'h1C);
    chk("t1_rel", kh[0], 0);
    chk("t1_cnt", pc0, 1);
    pop0("t1_mk", 8'h1C, 1'b0, 1'b0);
    pop0("t1_bk", 8'h1C, 1'b0, 1'b1);
    chk("t1_empty", if0.evt_valid, 0);

    // extended key
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    pop0("t2_mk", 8'h75, 1'b1, 1'b0);
    pop0("t2_bk", 8'h75, 1'b1, 1'b1);
    chk("t2_cnt", pc0, 1);
    chk("t2_empty", if0.evt_valid, 0);

    // typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    @(posedge clk); #1;
    pop0("t3_mk", 8'h1C, 1'b0, 1'b0);
    pop0("t3_bk", 8'h1C, 1'b0, 1'b1);
    chk("t3_empty", if0.evt_valid, 0);
    chk("t3_cnt", pc0, 1);
    chk("t3_ev1", n_ev1, 4);
    chk("t3_cnt1", pc1, 3);

    // overfill with no pops, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    chk("t4_drops", n_drop0, 1);
    chk("t4_cnt", pc0, 9);
    chk("t4_held", {kh[0], hc[0]}, {1'b1, 8'h18});
    kb_data = 8'h20; kb_ready = 1'b1; rdy0 = 1'b1;
    @(posedge clk); #1;
    kb_ready = 1'b0; rdy0 = 1'b0;
    @(posedge clk); #1;
    chk("t4_nodrop", n_drop0, 1);
    chk("t4_cnt2", pc0, 10);
    for (int i = 1; i < 8; i++) pop0("t4_pop", 8'h10 + 8'(i), 1'b0, 1'b0);
    pop0("t4_last", 8'h20, 1'b0, 1'b0);
    chk("t4_empty", if0.evt_valid, 0);

    // counter wrap and receiver overflow
    do_reset();
    rdy0 = 1'b1;
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i));
    chk("t5_cnt4", pc2, 1);
    chk("t5_cnt8", pc0, 17);
    send(8'hE0);
    kb_data = 8'h55; kb_ready = 1'b1; kb_overflow = 1'b1;
    @(posedge clk); #1;
    kb_ready = 1'b0; kb_overflow = 1'b0;
    chk("t5_clrn_lo", clrn[0], 0);
    chk("t5_ovf", ovf[0], 1);
    chk("t5_noacc", nd_n[0], 1);
    chk("t5_cntkeep", pc0, 17);
    @(posedge clk); #1;
    chk("t5_clrn_hi", clrn[0], 1);
    send(8'h1C);
    chk("t5_after", {kh[0], hc[0], hx[0]}, {1'b1, 8'h1C, 1'b0});
    chk("t5_cnt_after", pc0, 18);

    // reset drops a partial prefix; ignored codes; foreign break
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("t6_make", {kh[0], hc[0], hx[0]}, {1'b1, 8'h1C, 1'b0});
    chk("t6_cnt", pc0, 1);
    send(8'hAA); send(8'hFA);
    chk("t6_ign", pc0, 1);
    send(8'hF0); send(8'h22);
    chk("t6_foreign", kh[0], 1);
    send(8'hF0); send(8'h1C);
    chk("t6_rel", kh[0], 0);
    chk("t6_cnt2", pc0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
